// File: rtl/expr_seq_pkg.sv
// Shared definitions for the expression vector sequencer.
// Contents: default operand/result widths, MISR seed and default polynomial,
// the sequencer state enum, and the single-step MISR update function.
package expr_seq_pkg;

  localparam int A0_W_DEF       = 4;
  localparam int A1_W_DEF       = 6;
  localparam int B0_W_DEF       = 4;
  localparam int B1_W_DEF       = 6;
  localparam int Y_W_DEF        = 30;
  localparam int SETTLE_CYC_DEF = 1;
  localparam int CNT_W_DEF      = 16;

  localparam logic [31:0] MISR_SEED     = 32'hFFFF_FFFF;
  localparam logic [31:0] MISR_POLY_DEF = 32'h04C1_1DB7;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    EMIT    = 3'd4,
    DONE    = 3'd5
  } seq_state_t;

  // One MISR step: shift left, fold the polynomial in when the MSB falls
  // out, then mix in the (already zero-extended) data word.
  function automatic logic [31:0] misr_next(input logic [31:0] sig,
                                            input logic [31:0] data,
                                            input logic [31:0] poly);
    logic [31:0] fb;
    fb = sig[31] ? poly : 32'h0;
    return {sig[30:0], 1'b0} ^ fb ^ data;
  endfunction

endpackage

// File: rtl/expr_misr32.sv
// 32-bit multiple-input signature register.
// Ports:
//   clk, rst_n  : clock, async active-low reset (signature clears to 0)
//   load        : load MISR_SEED (takes priority over enable)
//   enable      : fold y_in into the signature this cycle
//   y_in        : result word, zero-extended to 32 bits
//   signature   : current signature value
module expr_misr32
  import expr_seq_pkg::*;
#(
  parameter int          Y_W  = Y_W_DEF,
  parameter logic [31:0] POLY = MISR_POLY_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           enable,
  input  logic [Y_W-1:0] y_in,
  output logic [31:0]    signature
);

  // Seed load starts a fresh run; otherwise fold each captured result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signature <= 32'h0;
    end else if (load) begin
      signature <= MISR_SEED;
    end else if (enable) begin
      signature <= misr_next(signature, 32'(y_in), POLY);
    end
  end

endmodule

// File: rtl/expr_vector_sequencer.sv
// Sequences operand vectors through an external combinational expression
// unit, one vector in flight at a time, and signs every captured result.
// Ports:
//   clk, rst_n               : clock, async active-low reset
//   start, abort, num_vec    : run control (start samples num_vec in IDLE)
//   in_valid/in_ready        : operand vector stream (in_a0..in_b1)
//   a0/a1/b0/b1              : registered operand drive to the expression unit
//   y                        : expression unit result
//   out_valid/out_ready      : result stream (out_y, out_idx)
//   busy, done               : run in progress / one-cycle end-of-run pulse
//   signature                : MISR over all results captured in the run
module expr_vector_sequencer
  import expr_seq_pkg::*;
#(
  parameter int          A0_W       = A0_W_DEF,
  parameter int          A1_W       = A1_W_DEF,
  parameter int          B0_W       = B0_W_DEF,
  parameter int          B1_W       = B1_W_DEF,
  parameter int          Y_W        = Y_W_DEF,
  parameter int          SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int          CNT_W      = CNT_W_DEF,
  parameter logic [31:0] MISR_POLY  = MISR_POLY_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A0_W-1:0]  in_a0,
  input  logic [A1_W-1:0]  in_a1,
  input  logic [B0_W-1:0]  in_b0,
  input  logic [B1_W-1:0]  in_b1,
  output logic [A0_W-1:0]  a0,
  output logic [A1_W-1:0]  a1,
  output logic [B0_W-1:0]  b0,
  output logic [B1_W-1:0]  b1,
  input  logic [Y_W-1:0]   y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Y_W-1:0]   out_y,
  output logic [CNT_W-1:0] out_idx,
  output logic             busy,
  output logic             done,
  output logic [31:0]      signature
);

  // Timer counts down from SETTLE_CYC-1, so it only needs to hold that value.
  localparam int TMR_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] idx_q;
  logic [TMR_W-1:0] timer_q;

  logic abort_act;
  logic start_run;
  logic load_ops;
  logic timer_dec;
  logic capture;
  logic emit_fire;

  assign abort_act = abort && (state_q != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath strobes. Abort from any active state overrides
  // every transition and suppresses all strobes, including the done pulse.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    done      = 1'b0;
    start_run = 1'b0;
    load_ops  = 1'b0;
    timer_dec = 1'b0;
    capture   = 1'b0;
    emit_fire = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_vec != '0) begin
            start_run = 1'b1;
            state_d   = FETCH;
          end else begin
            state_d   = DONE;
          end
        end
      end
      FETCH: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_ops = 1'b1;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (timer_q == '0) begin
          state_d = CAPTURE;
        end else begin
          timer_dec = 1'b1;
        end
      end
      CAPTURE: begin
        capture = 1'b1;
        state_d = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          emit_fire = 1'b1;
          state_d   = (rem_q == CNT_W'(1)) ? DONE : FETCH;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort_act) begin
      state_d   = IDLE;
      done      = 1'b0;
      load_ops  = 1'b0;
      timer_dec = 1'b0;
      capture   = 1'b0;
      emit_fire = 1'b0;
    end
  end

  // Operand, result and counter registers. Operands are only rewritten on an
  // accepted vector, so the expression unit sees stable inputs between runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0        <= '0;
      a1        <= '0;
      b0        <= '0;
      b1        <= '0;
      out_y     <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      idx_q     <= '0;
      rem_q     <= '0;
      timer_q   <= '0;
    end else begin
      if (start_run) begin
        rem_q <= num_vec;
        idx_q <= '0;
        busy  <= 1'b1;
      end
      if (load_ops) begin
        a0      <= in_a0;
        a1      <= in_a1;
        b0      <= in_b0;
        b1      <= in_b1;
        timer_q <= TMR_W'(SETTLE_CYC - 1);
      end
      if (timer_dec) begin
        timer_q <= timer_q - TMR_W'(1);
      end
      if (capture) begin
        out_y     <= y;
        out_idx   <= idx_q;
        out_valid <= 1'b1;
      end
      if (emit_fire) begin
        out_valid <= 1'b0;
        idx_q     <= idx_q + CNT_W'(1);
        rem_q     <= rem_q - CNT_W'(1);
      end
      if (state_q == DONE) begin
        busy <= 1'b0;
      end
      if (abort_act) begin
        busy      <= 1'b0;
        out_valid <= 1'b0;
      end
    end
  end

  expr_misr32 #(
    .Y_W  (Y_W),
    .POLY (MISR_POLY)
  ) u_misr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (start_run),
    .enable    (capture),
    .y_in      (y),
    .signature (signature)
  );

endmodule

// File: tb/tb_expr_vector_sequencer.sv
// Directed testbench for expr_vector_sequencer. Two instances share all
// inputs: dut1 uses SETTLE_CYC=1, dut3 uses SETTLE_CYC=3. The expression
// unit is either a bench-driven value or a small model fed from dut1's
// operand outputs.
module tb_expr_vector_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, in_valid, out_ready, use_model;
  logic [15:0] num_vec;
  logic [3:0]  in_a0, in_b0;
  logic [5:0]  in_a1, in_b1;
  logic [29:0] y, y_drv;

  logic        in_ready, out_valid, busy, done;
  logic [3:0]  a0, b0;
  logic [5:0]  a1, b1;
  logic [29:0] out_y;
  logic [15:0] out_idx;
  logic [31:0] signature;

  logic        s3_in_ready, s3_out_valid, s3_busy, s3_done;
  logic [3:0]  s3_a0, s3_b0;
  logic [5:0]  s3_a1, s3_b1;
  logic [29:0] s3_out_y;
  logic [15:0] s3_out_idx;
  logic [31:0] s3_signature;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  function automatic logic [29:0] expr_f(input logic [19:0] v);
    logic [29:0] t;
    t = {10'd0, v};
    return t * 30'd977 + 30'h0000_05A5;
  endfunction

  function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [29:0] yv);
    return {sig[30:0], 1'b0} ^ (sig[31] ? 32'h04C1_1DB7 : 32'h0) ^ {2'b00, yv};
  endfunction

  assign y = use_model ? expr_f({a0, a1, b0, b1}) : y_drv;

  expr_vector_sequencer #(.SETTLE_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_vec(num_vec),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a0(in_a0), .in_a1(in_a1), .in_b0(in_b0), .in_b1(in_b1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1), .y(y),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_idx(out_idx),
    .busy(busy), .done(done), .signature(signature)
  );

  expr_vector_sequencer #(.SETTLE_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_vec(num_vec),
    .in_valid(in_valid), .in_ready(s3_in_ready),
    .in_a0(in_a0), .in_a1(in_a1), .in_b0(in_b0), .in_b1(in_b1),
    .a0(s3_a0), .a1(s3_a1), .b0(s3_b0), .b1(s3_b1), .y(y),
    .out_valid(s3_out_valid), .out_ready(out_ready), .out_y(s3_out_y), .out_idx(s3_out_idx),
    .busy(s3_busy), .done(s3_done), .signature(s3_signature)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    use_model = 1'b0; num_vec = '0; y_drv = '0;
    {in_a0, in_a1, in_b0, in_b1} = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic start_run(input logic [15:0] n);
    start = 1'b1; num_vec = n;
    tick();
    start = 1'b0;
  endtask

  // Present a vector on dut1's input stream and wait until it is accepted.
  task automatic feed_vector(input logic [19:0] v, input logic [29:0] yv, input string tag);
    int cnt = 0;
    while (in_ready !== 1'b1 && cnt < 50) begin tick(); cnt++; end
    if (in_ready !== 1'b1) begin
      n_checks++;
      $display("[TB] FAIL %s_in_ready_timeout got %b exp 1", tag, in_ready);
    end
    {in_a0, in_a1, in_b0, in_b1} = v;
    y_drv = yv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input string tag);
    int cnt = 0;
    while (out_valid !== 1'b1 && cnt < 50) begin tick(); cnt++; end
    if (out_valid !== 1'b1) begin
      n_checks++;
      $display("[TB] FAIL %s_out_valid_timeout got %b exp 1", tag, out_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready got %b exp 0", in_ready); else n_pass++;
    n_checks++; if ({out_valid, busy, done} !== 3'b000) $display("[TB] FAIL reset_flags got %b exp 000", {out_valid, busy, done}); else n_pass++;
    n_checks++; if ({out_y, out_idx} !== 46'h0) $display("[TB] FAIL reset_out got %h exp 0", {out_y, out_idx}); else n_pass++;
    n_checks++; if ({a0, a1, b0, b1} !== 20'h0) $display("[TB] FAIL reset_ops got %h exp 0", {a0, a1, b0, b1}); else n_pass++;
    n_checks++; if (signature !== 32'h0) $display("[TB] FAIL reset_sig got %h exp 0", signature); else n_pass++;
  endtask

  task automatic test_zero_run();
    start_run(16'd0);
    n_checks++; if (done !== 1'b1) $display("[TB] FAIL zero_done got %b exp 1", done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL zero_busy got %b exp 0", busy); else n_pass++;
    tick();
    n_checks++; if ({done, busy} !== 2'b00) $display("[TB] FAIL zero_after got %b exp 00", {done, busy}); else n_pass++;
    n_checks++; if (signature !== 32'h0) $display("[TB] FAIL zero_sig got %h exp 0", signature); else n_pass++;
  endtask

  task automatic test_single();
    logic [31:0] exp_sig;
    exp_sig = misr_step(32'hFFFF_FFFF, 30'h155);
    start_run(16'd1);
    n_checks++; if ({busy, in_ready} !== 2'b11) $display("[TB] FAIL single_fetch got %b exp 11", {busy, in_ready}); else n_pass++;
    {in_a0, in_a1, in_b0, in_b1} = {4'h3, 6'h21, 4'h5, 6'h0A};
    y_drv = 30'h155; in_valid = 1'b1;
    tick();                                   // accept edge E
    in_valid = 1'b0;
    n_checks++; if ({a0, a1, b0, b1} !== {4'h3, 6'h21, 4'h5, 6'h0A}) $display("[TB] FAIL single_ops got %h exp %h", {a0, a1, b0, b1}, {4'h3, 6'h21, 4'h5, 6'h0A}); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("[TB] FAIL single_in_ready got %b exp 0", in_ready); else n_pass++;
    tick();                                   // E+1
    n_checks++; if (out_valid !== 1'b0) $display("[TB] FAIL single_early_valid got %b exp 0", out_valid); else n_pass++;
    tick();                                   // E+2
    n_checks++; if (out_valid !== 1'b1) $display("[TB] FAIL single_valid got %b exp 1", out_valid); else n_pass++;
    n_checks++; if (out_y !== 30'h155) $display("[TB] FAIL single_out_y got %h exp %h", out_y, 30'h155); else n_pass++;
    n_checks++; if (out_idx !== 16'd0) $display("[TB] FAIL single_out_idx got %0d exp 0", out_idx); else n_pass++;
    n_checks++; if (signature !== exp_sig) $display("[TB] FAIL single_sig got %h exp %h", signature, exp_sig); else n_pass++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if ({done, out_valid, busy} !== 3'b101) $display("[TB] FAIL single_done got %b exp 101", {done, out_valid, busy}); else n_pass++;
    tick();
    n_checks++; if ({done, busy} !== 2'b00) $display("[TB] FAIL single_idle got %b exp 00", {done, busy}); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [19:0] vecs [4];
    logic [29:0] ys   [4];
    vecs = '{20'h1_2345, 20'hA_BCDE, 20'h5_5AA5, 20'hF_0F0F};
    ys   = '{30'h0000_1111, 30'h0222_2222, 30'h1333_3333, 30'h2444_4444};
    start_run(16'd4);
    for (int k = 0; k < 4; k++) begin
      feed_vector(vecs[k], ys[k], "bp");
      wait_out_valid("bp");
      n_checks++; if (out_y !== ys[k]) $display("[TB] FAIL bp_out_y%0d got %h exp %h", k, out_y, ys[k]); else n_pass++;
      n_checks++; if (out_idx !== 16'(k)) $display("[TB] FAIL bp_out_idx%0d got %0d exp %0d", k, out_idx, k); else n_pass++;
      if (k == 2) begin
        {in_a0, in_a1, in_b0, in_b1} = vecs[3];
        in_valid = 1'b1;
        y_drv = 30'h3FFF_FFFF;
        for (int c = 0; c < 5; c++) begin
          n_checks++; if ({out_valid, in_ready} !== 2'b10) $display("[TB] FAIL bp_stall_hs%0d got %b exp 10", c, {out_valid, in_ready}); else n_pass++;
          n_checks++; if (out_y !== ys[2]) $display("[TB] FAIL bp_stall_y%0d got %h exp %h", c, out_y, ys[2]); else n_pass++;
          n_checks++; if ({a0, a1, b0, b1} !== vecs[2]) $display("[TB] FAIL bp_stall_ops%0d got %h exp %h", c, {a0, a1, b0, b1}, vecs[2]); else n_pass++;
          tick();
        end
        in_valid = 1'b0;
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    n_checks++; if (done !== 1'b1) $display("[TB] FAIL bp_done got %b exp 1", done); else n_pass++;
    tick();
  endtask

  task automatic test_abort();
    logic [31:0] sig0;
    sig0 = misr_step(32'hFFFF_FFFF, 30'h0ABC_DEF0);
    start_run(16'd3);
    feed_vector(20'h7_1234, 30'h0ABC_DEF0, "ab0");
    wait_out_valid("ab0");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    feed_vector(20'h2_4680, 30'h1111_0000, "ab1");   // now in SETTLE of vector 1
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++; if ({busy, out_valid, in_ready, done} !== 4'b0000) $display("[TB] FAIL abort_flags got %b exp 0000", {busy, out_valid, in_ready, done}); else n_pass++;
    n_checks++; if (signature !== sig0) $display("[TB] FAIL abort_sig_hold got %h exp %h", signature, sig0); else n_pass++;
    n_checks++; if (out_y !== 30'h0ABC_DEF0) $display("[TB] FAIL abort_y_hold got %h exp %h", out_y, 30'h0ABC_DEF0); else n_pass++;
    tick();
    n_checks++; if ({done, in_ready} !== 2'b00) $display("[TB] FAIL abort_no_done got %b exp 00", {done, in_ready}); else n_pass++;
    start_run(16'd1);
    feed_vector(20'h9_9999, 30'h0000_0777, "ab2");
    wait_out_valid("ab2");
    n_checks++; if (out_idx !== 16'd0) $display("[TB] FAIL abort_restart_idx got %0d exp 0", out_idx); else n_pass++;
    n_checks++; if (signature !== misr_step(32'hFFFF_FFFF, 30'h0000_0777)) $display("[TB] FAIL abort_restart_sig got %h exp %h", signature, misr_step(32'hFFFF_FFFF, 30'h0000_0777)); else n_pass++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (done !== 1'b1) $display("[TB] FAIL abort_restart_done got %b exp 1", done); else n_pass++;
    tick();
  endtask

  task automatic test_settle3();
    do_reset();
    start_run(16'd1);
    n_checks++; if (s3_in_ready !== 1'b1) $display("[TB] FAIL s3_in_ready got %b exp 1", s3_in_ready); else n_pass++;
    {in_a0, in_a1, in_b0, in_b1} = 20'hC_3F21;
    y_drv = 30'h0000_00AA; in_valid = 1'b1;
    tick();                                   // accept edge E
    in_valid = 1'b0;
    y_drv = 30'h0000_00BB; tick();            // E+1
    y_drv = 30'h0000_00CC; tick();            // E+2
    y_drv = 30'h0000_00DD; tick();            // E+3, now CAPTURE
    n_checks++; if (s3_out_valid !== 1'b0) $display("[TB] FAIL s3_early_valid got %b exp 0", s3_out_valid); else n_pass++;
    y_drv = 30'h2ABC_1234; tick();            // E+4
    n_checks++; if (s3_out_valid !== 1'b1) $display("[TB] FAIL s3_valid got %b exp 1", s3_out_valid); else n_pass++;
    n_checks++; if (s3_out_y !== 30'h2ABC_1234) $display("[TB] FAIL s3_out_y got %h exp %h", s3_out_y, 30'h2ABC_1234); else n_pass++;
    n_checks++; if (s3_signature !== misr_step(32'hFFFF_FFFF, 30'h2ABC_1234)) $display("[TB] FAIL s3_sig got %h exp %h", s3_signature, misr_step(32'hFFFF_FFFF, 30'h2ABC_1234)); else n_pass++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (s3_done !== 1'b1) $display("[TB] FAIL s3_done got %b exp 1", s3_done); else n_pass++;
    tick();
  endtask

  task automatic test_misr8();
    logic [19:0] vecs [8];
    logic [31:0] exp_sig;
    vecs = '{20'h0_0000, 20'hF_FFFF, 20'h1_0203, 20'h8_4210,
             20'h3_8421, 20'hA_5A5A, 20'h6_C3C3, 20'hE_0001};
    use_model = 1'b1;
    exp_sig = 32'hFFFF_FFFF;
    start_run(16'd8);
    for (int k = 0; k < 8; k++) begin
      feed_vector(vecs[k], 30'h0, "m8");
      wait_out_valid("m8");
      exp_sig = misr_step(exp_sig, expr_f(vecs[k]));
      n_checks++; if ({out_idx, out_y} !== {16'(k), expr_f(vecs[k])}) $display("[TB] FAIL m8_out%0d got %h exp %h", k, {out_idx, out_y}, {16'(k), expr_f(vecs[k])}); else n_pass++;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    n_checks++; if (done !== 1'b1) $display("[TB] FAIL m8_done got %b exp 1", done); else n_pass++;
    n_checks++; if (signature !== exp_sig) $display("[TB] FAIL m8_sig got %h exp %h", signature, exp_sig); else n_pass++;
    tick();
    n_checks++; if (signature !== exp_sig) $display("[TB] FAIL m8_sig_hold got %h exp %h", signature, exp_sig); else n_pass++;
    use_model = 1'b0;
  endtask

  task automatic test_reset_midrun();
    start_run(16'd2);
    feed_vector(20'h4_5678, 30'h1234_5678, "rm");
    wait_out_valid("rm");
    out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({out_valid, busy, done, in_ready} !== 4'b0000) $display("[TB] FAIL rm_flags got %b exp 0000", {out_valid, busy, done, in_ready}); else n_pass++;
    n_checks++; if ({out_y, out_idx, a0, a1, b0, b1} !== 66'h0) $display("[TB] FAIL rm_data got %h exp 0", {out_y, out_idx, a0, a1, b0, b1}); else n_pass++;
    n_checks++; if (signature !== 32'h0) $display("[TB] FAIL rm_sig got %h exp 0", signature); else n_pass++;
    tick();
    out_ready = 1'b0;
    rst_n = 1'b1;
    tick();
    n_checks++; if ({out_valid, busy, done} !== 3'b000) $display("[TB] FAIL rm_after got %b exp 000", {out_valid, busy, done}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_zero_run();
    test_single();
    test_backpressure();
    test_abort();
    test_settle3();
    test_misr8();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got running exp finished");
    $fatal(1, "[TB] simulation timeout");
  end

endmodule
